// File: rtl/snes_video_patgen.sv
// SNES-style 256x224 test-pattern source driving the retimer pixel input.
// Define VIDEO_PATGEN_BORDER_EN to add a white frame around the active area.
module snes_video_patgen #(
  parameter int DOT_DIV     = 4,
  parameter int H_ACTIVE    = 256,
  parameter int H_TOTAL     = 341,
  parameter int HSYNC_START = 274,
  parameter int HSYNC_LEN   = 25,
  parameter int V_ACTIVE    = 224,
  parameter int V_TOTAL     = 262
) (
  input  logic        input_clk,
  input  logic        rst_n,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        dot_clock,
  output logic [7:0]  R_out,
  output logic [7:0]  G_out,
  output logic [7:0]  B_out,
  output logic        out_valid,
  output logic        hsync,
  output logic        vblank,
  output logic [7:0]  frame_ctr
);

  localparam int DW = $clog2(DOT_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DOT_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DOT_DIV / 2);
  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(HSYNC_START);
  localparam logic [9:0] HS_END = 10'(HSYNC_START + HSYNC_LEN);
`ifdef VIDEO_PATGEN_BORDER_EN
  localparam logic [8:0] H_EDGE = 9'(H_ACTIVE - 1);
  localparam logic [8:0] V_EDGE = 9'(V_ACTIVE - 1);
`endif

  logic [DW-1:0] div_ctr;
  logic [DW-1:0] div_nx;
  logic [8:0]    hx;
  logic [8:0]    vy;
  logic [8:0]    hx_nx;
  logic [8:0]    vy_nx;
  logic [1:0]    pat_q;
  logic [1:0]    pat_nx;
  logic [7:0]    fc_nx;
  logic [23:0]   pix;
  logic [23:0]   rgb_nx;
  logic          first_q;
  logic          adv;
  logic          h_wrap;
  logic          f_wrap;
  logic          valid_nx;
  logic          hsync_nx;
  logic          vblank_nx;

  // first_q forces the dot advance on the first edge out of reset
  always_comb begin
    adv    = first_q || (div_ctr == DIV_LAST);
    div_nx = adv ? '0 : div_ctr + DW'(1);
    h_wrap = (hx == H_LAST);
    hx_nx  = h_wrap ? '0 : hx + 9'd1;
    vy_nx  = vy;
    if (h_wrap) begin
      vy_nx = (vy == V_LAST) ? '0 : vy + 9'd1;
    end
    f_wrap    = h_wrap && (vy == V_LAST) && !first_q;
    fc_nx     = frame_ctr + {7'd0, f_wrap};
    pat_nx    = (hx_nx == '0 && vy_nx == '0) ? pattern_sel : pat_q;
    valid_nx  = ({1'b0, hx_nx} < H_ACT) && ({1'b0, vy_nx} < V_ACT);
    hsync_nx  = ({1'b0, hx_nx} >= HS_BEG) && ({1'b0, hx_nx} < HS_END);
    vblank_nx = ({1'b0, vy_nx} >= V_ACT);

    pix = '0;
    unique case (pat_nx)
      2'd0: pix = {{8{~hx_nx[7]}}, {8{~hx_nx[6]}}, {8{~hx_nx[5]}}};
      2'd1: pix = {24{hx_nx[3] ^ vy_nx[3]}};
      2'd2: pix = {hx_nx[7:0], vy_nx[7:0], fc_nx};
      2'd3: pix = solid_rgb;
    endcase
`ifdef VIDEO_PATGEN_BORDER_EN
    if (hx_nx == '0 || hx_nx == H_EDGE ||
        vy_nx == '0 || vy_nx == V_EDGE) begin
      pix = 24'hFF_FFFF;
    end
`endif
    rgb_nx = valid_nx ? pix : '0;
  end

  always_ff @(posedge input_clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q   <= 1'b1;
      div_ctr   <= '0;
      hx        <= H_LAST;
      vy        <= V_LAST;
      pat_q     <= 2'd0;
      frame_ctr <= 8'd0;
      dot_clock <= 1'b0;
      R_out     <= 8'd0;
      G_out     <= 8'd0;
      B_out     <= 8'd0;
      out_valid <= 1'b0;
      hsync     <= 1'b0;
      vblank    <= 1'b1;
    end else begin
      first_q <= 1'b0;
      div_ctr <= div_nx;
      if (adv) begin
        hx        <= hx_nx;
        vy        <= vy_nx;
        pat_q     <= pat_nx;
        frame_ctr <= fc_nx;
        dot_clock <= 1'b1;
        {R_out, G_out, B_out} <= rgb_nx;
        out_valid <= valid_nx;
        hsync     <= hsync_nx;
        vblank    <= vblank_nx;
      end else if (div_nx == DIV_HALF) begin
        dot_clock <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snes_video_patgen.sv
// Bench for snes_video_patgen: reduced geometry, reference model derived
// from the elapsed-cycle count, vector table plus reset sequences.
module tb_snes_video_patgen;

  localparam int DD = 4;
  localparam int HA = 256;
  localparam int HT = 270;
  localparam int HS = 258;
  localparam int HL = 8;
  localparam int VA = 10;
  localparam int VT = 12;
  localparam logic [35:0] RST_VAL = {4'b0001, 8'h00, 24'h000000};

  logic        input_clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic        dot_clock;
  logic [7:0]  R_out, G_out, B_out;
  logic        out_valid, hsync, vblank;
  logic [7:0]  frame_ctr;

  snes_video_patgen #(
    .DOT_DIV(DD), .H_ACTIVE(HA), .H_TOTAL(HT), .HSYNC_START(HS),
    .HSYNC_LEN(HL), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .input_clk(input_clk), .rst_n(rst_n),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .dot_clock(dot_clock), .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .out_valid(out_valid), .hsync(hsync), .vblank(vblank),
    .frame_ctr(frame_ctr)
  );

  always #5 input_clk = ~input_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          ep;
    int          fr;
    int          x;
    int          y;
    logic [23:0] rgb;
    logic        vld;
  } vec_t;

  vec_t tbl[32];
  bit   hit[32];
  int   nt = 0;

  task automatic add(input int ep, input int fr, input int x, input int y,
                     input logic [23:0] rgb, input logic vld);
    tbl[nt] = '{ep, fr, x, y, rgb, vld};
    hit[nt] = 1'b0;
    nt++;
  endtask

  function automatic logic [23:0] ref_rgb(input int x, input int y,
                                          input int f, input logic [1:0] p,
                                          input logic [23:0] s);
    int b;
    if (!(x < HA && y < VA)) return 24'h0;
`ifdef VIDEO_PATGEN_BORDER_EN
    if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) return 24'hFFFFFF;
`endif
    case (p)
      2'd0: begin
        b = 7 - (x / 32) % 8;
        return {((b & 4) != 0) ? 8'hFF : 8'h00,
                ((b & 2) != 0) ? 8'hFF : 8'h00,
                ((b & 1) != 0) ? 8'hFF : 8'h00};
      end
      2'd1: return (((x / 8) % 2) != ((y / 8) % 2)) ? 24'hFFFFFF : 24'h0;
      2'd2: return {8'(x % 256), 8'(y % 256), 8'(f % 256)};
      default: return s;
    endcase
  endfunction

  function automatic logic [35:0] outs();
    return {dot_clock, out_valid, hsync, vblank, frame_ctr,
            R_out, G_out, B_out};
  endfunction

  task automatic chk(input string name, input logic [35:0] got,
                     input logic [35:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // model: position follows from edges elapsed since reset release
  int          t = -1;
  int          ep = 0;
  int          mph, mhx, mvy, mfr;
  logic [1:0]  mpat = 2'd0;
  logic [23:0] msolid = 24'h0;

  always @(negedge rst_n) t = -1;

  always @(posedge input_clk) begin
    int d;
    if (rst_n) begin
      t++;
      mph = t % DD;
      d   = t / DD;
      mhx = d % HT;
      mvy = (d / HT) % VT;
      mfr = d / (HT * VT);
      if (mph == 0) begin
        msolid = solid_rgb;
        if (mhx == 0 && mvy == 0) mpat = pattern_sel;
      end
    end
  end

  logic [35:0] exp_v;
  logic [23:0] want;
  logic        prev_hs = 1'b0;
  int          hs_rise = 0;
  int          hs_act  = 0;

  always @(negedge input_clk) begin
    if (t < 0) begin
      exp_v = RST_VAL;
    end else begin
      exp_v = {mph < DD / 2, mhx < HA && mvy < VA,
               mhx >= HS && mhx < HS + HL, mvy >= VA, 8'(mfr % 256),
               ref_rgb(mhx, mvy, mfr, mpat, msolid)};
    end
    total++;
    if (outs() !== exp_v) begin
      bad++;
      $display("FAIL cycle t=%0d ep=%0d f=%0d x=%0d y=%0d got=%h want=%h",
               t, ep, mfr, mhx, mvy, outs(), exp_v);
    end
    if (t >= 0 && mph == 1) begin
      for (int i = 0; i < nt; i++) begin
        if (tbl[i].ep == ep && tbl[i].fr == mfr &&
            tbl[i].x == mhx && tbl[i].y == mvy) begin
          hit[i] = 1'b1;
          want = tbl[i].rgb;
`ifdef VIDEO_PATGEN_BORDER_EN
          if (tbl[i].vld && (mhx == 0 || mhx == HA - 1 ||
                             mvy == 0 || mvy == VA - 1)) want = 24'hFFFFFF;
`endif
          total++;
          if ({R_out, G_out, B_out} !== want || out_valid !== tbl[i].vld) begin
            bad++;
            $display("FAIL vec%0d (%0d,%0d) f%0d got=%h/%b want=%h/%b",
                     i, mhx, mvy, mfr, {R_out, G_out, B_out}, out_valid,
                     want, tbl[i].vld);
          end
        end
      end
    end
    if (t >= 0 && ep == 0 && mfr < 4 && hsync && !prev_hs) begin
      hs_rise++;
      if (!vblank) hs_act++;
    end
    prev_hs = hsync;
  end

  task automatic wait_dot(input int f, input int x, input int y);
    bit ok = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge input_clk);
      if (t >= 0 && mfr == f && mhx == x && mvy == y) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_dot f%0d (%0d,%0d) got=timeout want=reached",
               f, x, y);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    add(0, 0, 0, 0, 24'h000000, 1'b1);
    add(0, 0, 17, 9, 24'h110900, 1'b1);
    add(0, 1, 0, 0, 24'h000001, 1'b1);
    add(0, 1, 17, 9, 24'h110901, 1'b1);
    add(0, 2, 0, 5, 24'hFFFFFF, 1'b1);
    add(0, 2, 31, 5, 24'hFFFFFF, 1'b1);
    add(0, 2, 32, 5, 24'hFFFF00, 1'b1);
    add(0, 2, 63, 5, 24'hFFFF00, 1'b1);
    add(0, 2, 64, 5, 24'hFF00FF, 1'b1);
    add(0, 2, 100, 5, 24'hFF0000, 1'b1);
    add(0, 2, 128, 5, 24'h00FFFF, 1'b1);
    add(0, 2, 160, 5, 24'h00FF00, 1'b1);
    add(0, 2, 192, 5, 24'h0000FF, 1'b1);
    add(0, 2, 224, 5, 24'h000000, 1'b1);
    add(0, 2, 255, 5, 24'h000000, 1'b1);
    add(0, 2, 256, 5, 24'h000000, 1'b0);
    add(0, 2, 269, 5, 24'h000000, 1'b0);
    add(0, 3, 0, 0, 24'h000000, 1'b1);
    add(0, 3, 8, 0, 24'hFFFFFF, 1'b1);
    add(0, 3, 8, 7, 24'hFFFFFF, 1'b1);
    add(0, 3, 8, 8, 24'h000000, 1'b1);
    add(0, 3, 3, 9, 24'hFFFFFF, 1'b1);
    add(0, 3, 0, 10, 24'h000000, 1'b0);
    add(0, 4, 0, 0, 24'h123456, 1'b1);
    add(0, 4, 100, 1, 24'h123456, 1'b1);
    add(0, 4, 255, 2, 24'h123456, 1'b1);
    add(0, 4, 256, 2, 24'h000000, 1'b0);

    rst_n = 1'b0;
    pattern_sel = 2'd2;
    solid_rgb = 24'h0;
    repeat (3) @(negedge input_clk);
    chk("reset", outs(), RST_VAL);
    #2 rst_n = 1'b1;
    @(posedge input_clk);
    #1 chk("first_edge", outs(), {4'b1100, 8'h00, 24'h000000});

    wait_dot(1, 0, 3);
    #2 pattern_sel = 2'd0;
    wait_dot(2, 0, 6);
    #2 pattern_sel = 2'd1;
    wait_dot(3, 0, 5);
    #2 pattern_sel = 2'd3;
    solid_rgb = 24'h123456;
    wait_dot(4, 0, 3);

    // pattern_sel churns mid-frame and must have no effect
    reached = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge input_clk);
      if (t >= 0 && mfr == 4 && mhx == 40 && mvy == 8) begin
        reached = 1'b1;
        break;
      end
      #2 pattern_sel = 2'($urandom);
      solid_rgb = 24'($urandom);
    end
    total++;
    if (!reached) begin
      bad++;
      $display("FAIL reach_reset_point got=timeout want=reached");
    end

    #2 ep++;
    rst_n = 1'b0;
    #1 chk("rst_async", outs(), RST_VAL);
    repeat (3) @(posedge input_clk);
    @(negedge input_clk);
    #2 pattern_sel = 2'd3;
    rst_n = 1'b1;
    @(posedge input_clk);
    #1 chk("restart", outs(),
           {4'b1100, 8'h00, ref_rgb(0, 0, 0, 2'd3, solid_rgb)});

    for (int i = 0; i < 2 * HT * DD; i++) begin
      @(negedge input_clk);
      #2 solid_rgb = 24'($urandom);
      pattern_sel = 2'($urandom);
    end

    chk("hsync_rises", 36'(hs_rise), 36'(4 * VT));
    chk("hsync_active", 36'(hs_act), 36'(4 * VA));
    begin
      int n = 0;
      for (int i = 0; i < nt; i++) n += int'(hit[i]);
      chk("table_cov", 36'(n), 36'(nt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
